// File: rtl/test_pattern_gen_if.sv
// Pixel-generator bundle: timing/mode inputs from the HDMI timing side, colour and status back.
interface test_pattern_gen_if #(
  parameter int COLOR_WIDTH = 8,
  parameter int POS_WIDTH   = 10
);
  logic [2:0]             mode;
  logic [POS_WIDTH-1:0]   hpos;
  logic [POS_WIDTH-1:0]   vpos;
  logic                   in_hblank;
  logic                   in_vblank;
  logic [COLOR_WIDTH-1:0] red;
  logic [COLOR_WIDTH-1:0] green;
  logic [COLOR_WIDTH-1:0] blue;
  logic [2:0]             active_mode;
  logic [7:0]             frame_count;
  logic [2:0]             heartbeat;

  modport master (
    output mode, hpos, vpos, in_hblank, in_vblank,
    input  red, green, blue, active_mode, frame_count, heartbeat
  );

  modport slave (
    input  mode, hpos, vpos, in_hblank, in_vblank,
    output red, green, blue, active_mode, frame_count, heartbeat
  );
endinterface

// File: rtl/test_pattern_gen.sv
// Video test-pattern generator: one registered cycle from pixel position to colour.
// No backpressure; mode is latched only at frame start, blanking forces black.
module test_pattern_gen #(
  parameter int COLOR_WIDTH  = 8,
  parameter int POS_WIDTH    = 10,
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int SPLIT_LINE   = 250,
  parameter int CHECK_SHIFT  = 5,
  parameter int BLINK_PERIOD = 13500000
) (
  input logic              clk,
  input logic              reset,
  test_pattern_gen_if.slave pg
);

  localparam int BAR_W = H_ACTIVE / 8;
  localparam int DIV_W = (BLINK_PERIOD > 0) ? $clog2(BLINK_PERIOD + 1) : 1;
  localparam logic [COLOR_WIDTH-1:0] ALL_ONES  = '1;
  localparam logic [POS_WIDTH:0]     SCROLL_H  = (POS_WIDTH + 1)'(16);
  localparam logic [POS_WIDTH-1:0]   SPLIT_V   = POS_WIDTH'(SPLIT_LINE);
  localparam logic [POS_WIDTH-1:0]   SCROLL_MX = POS_WIDTH'(V_ACTIVE - 1);
  localparam logic [DIV_W-1:0]       DIV_TC    = DIV_W'(BLINK_PERIOD);

  logic [COLOR_WIDTH-1:0] r_red, r_green, r_blue;
  logic [2:0]             r_active_mode;
  logic [7:0]             r_frame_count;
  logic [2:0]             r_heartbeat;
  logic [DIV_W-1:0]       r_div;
  logic [POS_WIDTH-1:0]   r_scroll;
  logic                   r_vblank_d;

  logic                   w_frame_start;
  logic [2:0]             w_bar_idx;
  logic [2:0]             w_bar_col;
  logic                   w_cell;
  logic [POS_WIDTH:0]     w_v_ext;
  logic [POS_WIDTH:0]     w_sc_ext;
  logic                   w_in_scroll;
  logic [COLOR_WIDTH-1:0] w_red, w_green, w_blue;

  assign w_frame_start = pg.in_vblank & ~r_vblank_d;

  always_comb begin
    w_bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (int'(pg.hpos) >= k * BAR_W) w_bar_idx = w_bar_idx + 3'd1;
    end
    w_bar_col = 3'd7 - w_bar_idx;
  end

  assign w_cell      = pg.hpos[CHECK_SHIFT] ^ pg.vpos[CHECK_SHIFT] ^ r_frame_count[5];
  // One extra bit so a bar near the bottom does not wrap back to the top.
  assign w_v_ext     = {1'b0, pg.vpos};
  assign w_sc_ext    = {1'b0, r_scroll};
  assign w_in_scroll = (w_v_ext >= w_sc_ext) && (w_v_ext < w_sc_ext + SCROLL_H);

  always_comb begin
    w_red   = '0;
    w_green = '0;
    w_blue  = '0;
    case (r_active_mode)
      3'd0: begin
        if (pg.vpos < SPLIT_V) w_red  = ALL_ONES;
        else                   w_blue = ALL_ONES;
      end
      3'd1: begin
        w_red   = {COLOR_WIDTH{w_bar_col[2]}};
        w_green = {COLOR_WIDTH{w_bar_col[1]}};
        w_blue  = {COLOR_WIDTH{w_bar_col[0]}};
      end
      3'd2: begin
        w_red   = {COLOR_WIDTH{w_cell}};
        w_green = {COLOR_WIDTH{w_cell}};
        w_blue  = {COLOR_WIDTH{w_cell}};
      end
      3'd3: begin
        w_red   = COLOR_WIDTH'(pg.hpos);
        w_green = COLOR_WIDTH'(pg.vpos);
        w_blue  = COLOR_WIDTH'(r_frame_count);
      end
      3'd4: begin
        w_red   = {COLOR_WIDTH{w_in_scroll}};
        w_green = {COLOR_WIDTH{w_in_scroll}};
        w_blue  = {COLOR_WIDTH{w_in_scroll}};
      end
      default: ;
    endcase
  end

  // vblank_d resets high so a vblank already asserted out of reset is not a frame start.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_red         <= '0;
      r_green       <= '0;
      r_blue        <= '0;
      r_active_mode <= 3'd0;
      r_frame_count <= 8'd0;
      r_scroll      <= '0;
      r_vblank_d    <= 1'b1;
    end else begin
      r_vblank_d <= pg.in_vblank;
      if (w_frame_start) begin
        r_active_mode <= pg.mode;
        r_frame_count <= r_frame_count + 8'd1;
        r_scroll      <= (r_scroll == SCROLL_MX) ? '0 : r_scroll + 1'b1;
      end
      if (pg.in_hblank || pg.in_vblank) begin
        r_red   <= '0;
        r_green <= '0;
        r_blue  <= '0;
      end else begin
        r_red   <= w_red;
        r_green <= w_green;
        r_blue  <= w_blue;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div       <= '0;
      r_heartbeat <= 3'd0;
    end else if (r_div == DIV_TC) begin
      r_div       <= '0;
      r_heartbeat <= r_heartbeat + 3'd1;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign pg.red         = r_red;
  assign pg.green       = r_green;
  assign pg.blue        = r_blue;
  assign pg.active_mode = r_active_mode;
  assign pg.frame_count = r_frame_count;
  assign pg.heartbeat   = r_heartbeat;

endmodule

// File: tb/tb_test_pattern_gen.sv
// Scoreboard bench for test_pattern_gen: driver pushes expected results, monitor pops per cycle.
module tb_test_pattern_gen;

  localparam int SPLIT  = 250;
  localparam int BAR    = 640 / 8;
  localparam int VACT   = 480;
  localparam int BLINK  = 3;

  typedef struct {
    int due;
    int r, g, b, am, fc, hb;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  // reference state: what the generator should hold after the last sampled edge
  int m_am, m_fc, m_sc, m_n;
  bit m_vbd;

  test_pattern_gen_if #(.COLOR_WIDTH(8), .POS_WIDTH(10)) bus ();

  test_pattern_gen #(.BLINK_PERIOD(BLINK)) dut (
    .clk  (clk),
    .reset(reset),
    .pg   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void model_rgb(input int m, input int h, input int v, input int fc,
                                    input int sc, output int r, output int g, output int b);
    int idx, c;
    r = 0; g = 0; b = 0;
    case (m)
      0: if (v < SPLIT) r = 255; else b = 255;
      1: begin
        idx = h / BAR;
        if (idx > 7) idx = 7;
        c = 7 - idx;
        r = ((c >> 2) & 1) * 255;
        g = ((c >> 1) & 1) * 255;
        b = (c & 1) * 255;
      end
      2: if ((((h >> 5) ^ (v >> 5) ^ (fc >> 5)) & 1) == 1) begin r = 255; g = 255; b = 255; end
      3: begin r = h % 256; g = v % 256; b = fc % 256; end
      4: if (v >= sc && v < sc + 16) begin r = 255; g = 255; b = 255; end
      default: ;
    endcase
  endfunction

  task automatic step(input int m, input int h, input int v, input bit hb, input bit vb,
                      input bit rst);
    exp_t e;
    @(posedge clk);
    #1;
    bus.mode      = 3'(m);
    bus.hpos      = 10'(h);
    bus.vpos      = 10'(v);
    bus.in_hblank = hb;
    bus.in_vblank = vb;
    reset         = rst;
    e.due = cyc + 1;
    if (rst) begin
      e.r = 0; e.g = 0; e.b = 0;
      m_am = 0; m_fc = 0; m_sc = 0; m_vbd = 1'b1; m_n = 0;
    end else begin
      if (hb || vb) begin
        e.r = 0; e.g = 0; e.b = 0;
      end else begin
        model_rgb(m_am, h, v, m_fc, m_sc, e.r, e.g, e.b);
      end
      if (vb && !m_vbd) begin
        m_am = m;
        m_fc = (m_fc + 1) % 256;
        m_sc = (m_sc + 1) % VACT;
      end
      m_vbd = vb;
      m_n++;
    end
    e.am = m_am;
    e.fc = m_fc;
    e.hb = (m_n / (BLINK + 1)) % 8;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      n_tests++;
      if (int'(bus.red) != e.r || int'(bus.green) != e.g || int'(bus.blue) != e.b ||
          int'(bus.active_mode) != e.am || int'(bus.frame_count) != e.fc ||
          int'(bus.heartbeat) != e.hb) begin
        n_fail++;
        $display("FAIL pixel cyc=%0d got rgb=%0d,%0d,%0d am=%0d fc=%0d hb=%0d want rgb=%0d,%0d,%0d am=%0d fc=%0d hb=%0d",
                 cyc, bus.red, bus.green, bus.blue, bus.active_mode, bus.frame_count,
                 bus.heartbeat, e.r, e.g, e.b, e.am, e.fc, e.hb);
      end
    end
  end

  initial begin
    bus.mode = 3'd0; bus.hpos = '0; bus.vpos = '0;
    bus.in_hblank = 1'b0; bus.in_vblank = 1'b1; reset = 1'b1;
    m_am = 0; m_fc = 0; m_sc = 0; m_n = 0; m_vbd = 1'b1;

    // reset with vblank held high: no frame start until vblank falls and rises again
    repeat (3) step(2, 0, 0, 0, 1, 1);
    repeat (3) step(2, 0, 0, 0, 1, 0);
    step(0, 10, 10, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);

    // split pattern around the boundary line
    step(0, 100, 249, 0, 0, 0);
    step(0, 100, 250, 0, 0, 0);
    step(0, 100, 0, 0, 0, 0);

    // mode 1 requested mid-frame stays pending; hblank forces black
    step(1, 80, 100, 0, 0, 0);
    step(1, 80, 300, 1, 0, 0);
    step(1, 0, 0, 0, 1, 0);
    step(1, 79, 10, 0, 0, 0);
    step(1, 80, 10, 0, 0, 0);
    step(1, 639, 10, 0, 0, 0);
    for (int k = 0; k < 8; k++) step(1, k * BAR + $urandom_range(0, BAR - 1), 10, 0, 0, 0);
    step(1, 1023, 10, 0, 0, 0);

    // scroll bar across the wrap of scroll and frame_count
    for (int f = 0; f < 500; f++) begin
      step(4, 0, 0, 0, 1, 0);
      step(4, $urandom_range(0, 639), $urandom_range(0, 1023), 0, 0, 0);
      step(4, 1, m_sc, 0, 0, 0);
      step(4, 1, m_sc + 15, 0, 0, 0);
      step(4, 1, m_sc + 16, 0, 0, 0);
      if (m_sc > 0) step(4, 1, m_sc - 1, 0, 0, 0);
      if (m_sc == 470) begin
        step(4, 3, 479, 0, 0, 0);
        step(4, 3, 5, 0, 0, 0);
      end
    end

    // random frames, modes and pixels; resets only in the second half
    for (int f = 0; f < 80; f++) begin
      int m;
      m = $urandom_range(0, 7);
      repeat ($urandom_range(1, 3)) step(m, 0, 0, $urandom_range(0, 1), 1, 0);
      for (int p = 0; p < 30; p++) begin
        step($urandom_range(0, 7), $urandom_range(0, 1023), $urandom_range(0, 1023),
             ($urandom_range(0, 7) == 0), 0, (f >= 40) && ($urandom_range(0, 99) == 0));
      end
    end
    step(0, 0, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending entries want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
